instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/instruction_fetch_queue.sv | 106 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: types and constants shared by the fetch front end.
package riscv_pipe_pkg;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with synchronous clear.
// A pop on empty is ignored; a push on full is taken only alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr, wrPtr;
  logic             doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  // Pointers and occupancy; clear empties the queue in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage needs no reset: the head is only consumed while not empty
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: issues sequential fetches, tags in-order
// responses with their PC and buffers them for Decode. Redirects flush the
// queue and discard responses that were already in flight.
// Optional IFQ_BYPASS_EN: a response into an empty queue is presented to
// Decode in the same cycle.
module instruction_fetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fpc, rpc;
  logic [CW-1:0] outstanding, outstandingNext, dropCnt, fifoCount;
  logic [CW:0]   inUse;
  logic          fifoFull, fifoEmpty;
  logic          issue, respLive, pushEn, popEn;
  ifq_entry_t    head, pushEntry, decEntry;

  // Queued entries plus in-flight requests must never exceed the queue size
  assign inUse          = {1'b0, fifoCount} + {1'b0, outstanding};
  assign imem_req_valid = reset && !redirect && (inUse < DEPTH_W);
  assign imem_req_addr  = fpc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign respLive       = reset && imem_resp_valid && !redirect && (dropCnt == '0);
  assign pushEntry      = '{pc: rpc, instr: imem_resp_data};

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = respLive && fifoEmpty;
  assign dec_valid = !fifoEmpty || bypass;
  assign decEntry  = fifoEmpty ? pushEntry : head;
  assign pushEn    = respLive && !(bypass && dec_ready);
`else
  assign dec_valid = !fifoEmpty;
  assign decEntry  = head;
  assign pushEn    = respLive;
`endif

  assign popEn        = dec_valid && dec_ready && !redirect && !fifoEmpty;
  assign dec_instr    = dec_valid ? decEntry.instr : '0;
  assign dec_pc       = dec_valid ? decEntry.pc : '0;
  assign dec_pc_plus4 = dec_valid ? decEntry.pc + INSTR_BYTES : '0;

  // In-flight count after this cycle; every response retires one, live or not
  always_comb begin
    outstandingNext = outstanding;
    if (issue) outstandingNext = outstandingNext + CW'(1);
    if (imem_resp_valid && outstanding != '0) outstandingNext = outstandingNext - CW'(1);
  end

  // Fetch/response PCs, in-flight tracking and post-redirect drop window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (redirect) begin
        fpc     <= redirect_pc;
        rpc     <= redirect_pc;
        dropCnt <= outstandingNext;
      end else begin
        if (issue) fpc <= fpc + INSTR_BYTES;
        if (imem_resp_valid && dropCnt != '0) dropCnt <= dropCnt - CW'(1);
        if (respLive) rpc <= rpc + INSTR_BYTES;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ifq_entry_t))) uFifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (pushEn),
    .pop   (popEn),
    .din   (pushEntry),
    .dout  (head),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // The issue throttle makes a push into a full queue impossible
  ovfChk: assert property (@(posedge clk) disable iff (!reset) !(pushEn && fifoFull));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: a cycle table driven by hand,
// then memory-model sequences for stall, redirect and reset corner cases.
module tb_instruction_fetch_queue;
  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;

  int checks = 0, errors = 0;
  int pops = 0;
  logic [31:0] expPc;

  // response source: memory model or direct table drive
  logic        memOn, mRespValid, tRespValid;
  logic [31:0] mRespData, tRespData;
  int          memLat, cyc;
  logic [31:0] pq[$];
  int          pd[$];

  assign imem_resp_valid = memOn ? mRespValid : tRespValid;
  assign imem_resp_data  = memOn ? mRespData  : tRespData;

  instruction_fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // in-order memory: accepted at an edge, answered memLat edges later
  always begin
    @(posedge clk);
    if (reset && imem_req_valid && imem_req_ready) begin
      pq.push_back(imem_req_addr);
      pd.push_back(cyc + memLat);
    end
    cyc++;
    #1;
    if (!reset) begin pq.delete(); pd.delete(); end
    if (pq.size() != 0 && pd[0] <= cyc) begin
      mRespValid = 1'b1;
      mRespData  = instrOf(pq[0]);
      void'(pq.pop_front());
      void'(pd.pop_front());
    end else begin
      mRespValid = 1'b0;
      mRespData  = '0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted Decode entry must be the next sequential PC
  task automatic mon();
    if (dec_valid && dec_ready && !redirect) begin
      chk("sb dec_pc", dec_pc, expPc);
      chk("sb dec_pc_plus4", dec_pc_plus4, expPc + 32'd4);
      chk("sb dec_instr", dec_instr, instrOf(expPc));
      expPc = expPc + 32'd4;
      pops++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      #1; mon();
      @(negedge clk); #1;
    end
  endtask

  task automatic doReset(input int lat);
    reset = 0; memOn = 1; memLat = lat;
    imem_req_ready = 1; dec_ready = 1; redirect = 0; redirect_pc = '0;
    @(negedge clk); @(negedge clk); #1;
    reset = 1; expPc = 32'h0; pops = 0;
  endtask

  typedef struct {
    logic rdy; logic rv; logic [31:0] rd; logic redir; logic [31:0] rpcIn; logic dr;
    logic eReqV; logic [31:0] eAddr; logic eDecV; logic [31:0] ePc; logic [31:0] eInstr;
  } vec_t;

  function automatic vec_t mk(input int rdy, input int rv, input logic [31:0] rd,
                              input int redir, input logic [31:0] rpcIn, input int dr,
                              input int eReqV, input logic [31:0] eAddr, input int eDecV,
                              input logic [31:0] ePc, input logic [31:0] eInstr);
    vec_t v;
    v.rdy = (rdy != 0); v.rv = (rv != 0); v.rd = rd; v.redir = (redir != 0);
    v.rpcIn = rpcIn; v.dr = (dr != 0); v.eReqV = (eReqV != 0); v.eAddr = eAddr;
    v.eDecV = (eDecV != 0); v.ePc = ePc; v.eInstr = eInstr;
    return v;
  endfunction

  vec_t vt[22];
  int   p0;

  initial begin
    reset = 0; memOn = 0; memLat = 1; cyc = 0; expPc = '0;
    tRespValid = 0; tRespData = '0; mRespValid = 0; mRespData = '0;
    imem_req_ready = 0; dec_ready = 0; redirect = 0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_valid", imem_req_valid, 0);
    chk("reset req_addr", imem_req_addr, 32'h0);
    chk("reset dec_valid", dec_valid, 0);
    chk("reset dec_pc_plus4", dec_pc_plus4, 0);

`ifndef IFQ_BYPASS_EN
    //           rdy rv data          rd pc            dr | reqV addr          decV pc            instr
    vt[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0);
    vt[1]  = mk(1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0);
    vt[2]  = mk(1, 1, 32'h1111_0000, 0, 32'h0,         0,   1, 32'h4,         0, 32'h0,         32'h0);
    vt[3]  = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h8,         1, 32'h0,         32'h1111_0000);
    vt[4]  = mk(1, 1, 32'h1111_0001, 0, 32'h0,         0,   1, 32'h8,         1, 32'h0,         32'h1111_0000);
    vt[5]  = mk(1, 0, 32'h0,         0, 32'h0,         0,   1, 32'hC,         1, 32'h0,         32'h1111_0000);
    vt[6]  = mk(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h10,        1, 32'h0,         32'h1111_0000);
    vt[7]  = mk(1, 1, 32'h1111_0002, 0, 32'h0,         1,   0, 32'h10,        1, 32'h0,         32'h1111_0000);
    vt[8]  = mk(1, 1, 32'h1111_0003, 0, 32'h0,         1,   1, 32'h10,        1, 32'h4,         32'h1111_0001);
    vt[9]  = mk(1, 1, 32'h1111_0004, 1, 32'h100,       1,   0, 32'h14,        1, 32'h8,         32'h1111_0002);
    vt[10] = mk(0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         32'h0);
    vt[11] = mk(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         32'h0);
    vt[12] = mk(0, 1, 32'h1111_0005, 0, 32'h0,         1,   1, 32'h104,       0, 32'h0,         32'h0);
    vt[13] = mk(0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h104,       1, 32'h100,       32'h1111_0005);
    vt[14] = mk(0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h104,       0, 32'h0,         32'h0);
    vt[15] = mk(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h104,       0, 32'h0,         32'h0);
    vt[16] = mk(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h108,       0, 32'h0,         32'h0);
    vt[17] = mk(1, 1, 32'h1111_0006, 1, 32'hFFFF_FFFC, 1,   0, 32'h10C,       0, 32'h0,         32'h0);
    vt[18] = mk(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    vt[19] = mk(0, 1, 32'h1111_0007, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         32'h0);
    vt[20] = mk(0, 1, 32'h1111_0008, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         32'h0);
    vt[21] = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h1111_0008);

    reset = 1;
    for (int r = 0; r < 22; r++) begin
      imem_req_ready = vt[r].rdy; tRespValid = vt[r].rv; tRespData = vt[r].rd;
      redirect = vt[r].redir; redirect_pc = vt[r].rpcIn; dec_ready = vt[r].dr;
      #1;
      chk($sformatf("row%0d req_valid", r), imem_req_valid, vt[r].eReqV);
      chk($sformatf("row%0d req_addr", r), imem_req_addr, vt[r].eAddr);
      chk($sformatf("row%0d dec_valid", r), dec_valid, vt[r].eDecV);
      chk($sformatf("row%0d dec_pc", r), dec_pc, vt[r].ePc);
      chk($sformatf("row%0d dec_instr", r), dec_instr, vt[r].eInstr);
      chk($sformatf("row%0d dec_pc_plus4", r), dec_pc_plus4,
          vt[r].eDecV ? vt[r].ePc + 32'd4 : 32'h0);
      @(negedge clk); #1;
    end
    tRespValid = 0; redirect = 0;
`endif

    // A: streaming from reset with a one-cycle memory
    doReset(1);
    #1;
    chk("A first req_valid", imem_req_valid, 1);
    chk("A first req_addr", imem_req_addr, 32'h0);
    mon();
    @(negedge clk); #1;
    chk("A addr after first edge", imem_req_addr, 32'h4);
    step(30);
    chk("A stream progress", (pops >= 20), 1);

    // B: Decode stalls for 10 cycles, queue fills, nothing lost afterwards
    dec_ready = 0;
    step(10);
    chk("B fifo count", dut.uFifo.count, 4);
    chk("B req_valid while full", imem_req_valid, 0);
    dec_ready = 1; p0 = pops;
    step(15);
    chk("B drain progress", (pops - p0 >= 10), 1);

    // C: redirect with three requests in flight on a three-cycle memory
    doReset(3);
    step(3);
    chk("C outstanding", dut.outstanding, 3);
    chk("C response in redirect cycle", imem_resp_valid, 1);
    redirect = 1; redirect_pc = 32'h100; expPc = 32'h100;
    step(1);
    redirect = 0;
    chk("C drop window", dut.dropCnt, 2);
    chk("C fetch addr", imem_req_addr, 32'h100);
    p0 = pops;
    step(20);
    chk("C post-redirect progress", (pops - p0 >= 5), 1);

    // D: redirect colliding with a response and a Decode pop
    doReset(1);
    step(8);
    chk("D response present", imem_resp_valid, 1);
    chk("D dec_valid present", dec_valid, 1);
    redirect = 1; redirect_pc = 32'h200; expPc = 32'h200;
    step(1);
    redirect = 0;
    chk("D queue empty", dec_valid, 0);
    chk("D fifo count", dut.uFifo.count, 0);
    chk("D fetch addr", imem_req_addr, 32'h200);
    p0 = pops;
    step(12);
    chk("D post-redirect progress", (pops - p0 >= 8), 1);

    // E: asynchronous reset with two requests in flight
    doReset(3);
    step(2);
    chk("E outstanding", dut.outstanding, 2);
    @(posedge clk); #2;
    reset = 0;
    #1;
    chk("E req_valid", imem_req_valid, 0);
    chk("E req_addr", imem_req_addr, 32'h0);
    chk("E dec_valid", dec_valid, 0);
    chk("E dec_instr", dec_instr, 0);
    chk("E dec_pc", dec_pc, 0);
    chk("E dec_pc_plus4", dec_pc_plus4, 0);
    chk("E outstanding cleared", dut.outstanding, 0);
    @(negedge clk); @(negedge clk); #1;
    reset = 1; expPc = 32'h0; pops = 0;
    step(15);
    chk("E restart progress", (pops >= 5), 1);

`ifdef IFQ_BYPASS_EN
    // bypass: response into an empty queue reaches Decode in the same cycle
    doReset(1);
    memOn = 0; tRespValid = 0;
    @(negedge clk); #1;
    imem_req_ready = 0; tRespValid = 1; tRespData = 32'h0050_0093; dec_ready = 1;
    #1;
    chk("BYP dec_valid", dec_valid, 1);
    chk("BYP dec_instr", dec_instr, 32'h0050_0093);
    chk("BYP dec_pc", dec_pc, 32'h0);
    @(negedge clk); #1;
    tRespValid = 0;
    #1;
    chk("BYP entry not written", dec_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
